instr_sequencer: RTL

Multi-cycle control sequencer for the processor datapath. It accepts a decoded one-hot opcode and steps the datapath through FETCH/DECODE/EXEC/MEM/WB. In each step it drives the 7-bit control word to the ALU, register file, memory and PC logic. It sits between the instruction decoder and the datapath, and replaces the purely combinational opcode-to-control mapping when the design runs multi-cycle.

---
 rtl/instr_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// instr_sequencer
//
// Multi-cycle control sequencer. Steps the datapath through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for one decoded one-hot opcode
// and drives the 7-bit control word in each step.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous, active-low reset
//   start      in   begin one instruction (sampled only in IDLE)
//   op_onehot  in   [63:0] decoded opcode (ADD=4, MOVL=12, MOVS=13, JA=14,
//                   AND=25, CMP=59), captured in DECODE
//   mem_ready  in   memory finished the current FETCH / MEM access
//   cmp_gt     in   ALU "greater" flag, captured in EXEC of CMP
//   ctrl       out  [6:0] {reg_write, alu_src_imm, alu_op[1:0],
//                   mem_write, mem_to_reg, branch}
//   ir_load    out  load instruction register (FETCH)
//   pc_en      out  advance/load PC (retire cycle)
//   busy       out  not in IDLE
//   done       out  one-cycle retire pulse
//   illegal    out  one-cycle pulse in TRAP
//   retired    out  [15:0] retired-instruction count (wraps)
//
// Build option: define SEQ_STALL_TIMEOUT_EN to abandon a FETCH/MEM wait
// that lasts TIMEOUT cycles (goes to TRAP). Without it the sequencer
// waits for mem_ready indefinitely.
module instr_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] op_onehot,
  input  logic        mem_ready,
  input  logic        cmp_gt,
  output logic [6:0]  ctrl,
  output logic        ir_load,
  output logic        pc_en,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int OP_ADD  = 4;
  localparam int OP_MOVL = 12;
  localparam int OP_MOVS = 13;
  localparam int OP_JA   = 14;
  localparam int OP_AND  = 25;
  localparam int OP_CMP  = 59;

  localparam logic [63:0] LEGAL_OPS = (64'd1 << OP_ADD) | (64'd1 << OP_MOVL) |
                                      (64'd1 << OP_MOVS) | (64'd1 << OP_JA) |
                                      (64'd1 << OP_AND) | (64'd1 << OP_CMP);

  // Positions inside op_q. Only the legal opcode bits are kept: an opcode
  // with any other bit set traps straight out of DECODE and never needs op_q.
  localparam int Q_ADD  = 0;
  localparam int Q_MOVL = 1;
  localparam int Q_MOVS = 2;
  localparam int Q_JA   = 3;
  localparam int Q_AND  = 4;
  localparam int Q_CMP  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] op_q;
  logic       gt_q;
  logic       retire;
  logic       op_legal;
  logic       stall_timeout;

  // Exactly one bit set, and that bit is one of the six known opcodes.
  assign op_legal = (op_onehot != 64'd0) &&
                    ((op_onehot & (op_onehot - 64'd1)) == 64'd0) &&
                    ((op_onehot & ~LEGAL_OPS) == 64'd0);

`ifdef SEQ_STALL_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Counts cycles spent waiting in FETCH/MEM; any state change clears it,
  // so every entry into a wait state starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if ((state_reg == FETCH || state_reg == MEM) && state_next == state_reg) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Registered count at the limit: overrides a mem_ready arriving now.
  assign stall_timeout = (wait_cnt == CW'(TIMEOUT));
`else
  // No wait counter in this build; TIMEOUT has no effect.
  assign stall_timeout = 1'b0 & (TIMEOUT > 0);
`endif

  always_comb begin
    state_next = state_reg;
    ctrl       = 7'b0000000;
    ir_load    = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        ir_load = 1'b1;
        if (stall_timeout)  state_next = TRAP;
        else if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        state_next = op_legal ? EXEC : TRAP;
      end
      EXEC: begin
        case (1'b1)
          op_q[Q_ADD]:  state_next = WB;
          op_q[Q_AND]:  begin ctrl = 7'b0001000; state_next = WB;  end
          op_q[Q_MOVL]: begin ctrl = 7'b0100000; state_next = MEM; end
          op_q[Q_MOVS]: begin ctrl = 7'b0100000; state_next = MEM; end
          op_q[Q_CMP]:  begin ctrl = 7'b0010000; retire = 1'b1;    end
          op_q[Q_JA]:   begin ctrl = {6'b000000, gt_q}; retire = 1'b1; end
          default:      state_next = TRAP;
        endcase
      end
      MEM: begin
        ctrl = op_q[Q_MOVS] ? 7'b0100100 : 7'b0100010;
        if (stall_timeout) begin
          state_next = TRAP;
        end else if (mem_ready) begin
          // MOVS retires in the MEM cycle that completes the store, so its
          // done/pc_en are qualified by mem_ready; every other output is
          // decoded from registered state only.
          if (op_q[Q_MOVS]) retire = 1'b1;
          else              state_next = WB;
        end
      end
      WB: begin
        case (1'b1)
          op_q[Q_ADD]:  ctrl = 7'b1000000;
          op_q[Q_AND]:  ctrl = 7'b1001000;
          op_q[Q_MOVL]: ctrl = 7'b1100010;
          default:      ctrl = 7'b0000000;
        endcase
        retire = 1'b1;
      end
      TRAP: begin
        illegal    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (retire) state_next = IDLE;
  end

  assign done  = retire;
  assign pc_en = retire;
  assign busy  = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      op_q      <= '0;
      gt_q      <= 1'b0;
      retired   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) begin
        op_q <= {op_onehot[OP_CMP], op_onehot[OP_AND], op_onehot[OP_JA],
                 op_onehot[OP_MOVS], op_onehot[OP_MOVL], op_onehot[OP_ADD]};
      end
      if (state_reg == EXEC && op_q[Q_CMP]) gt_q <= cmp_gt;
      if (retire) retired <= retired + 16'd1;
    end
  end

endmodule
